// File: rtl/fs_accel_pkg.sv
// Shared constants and helpers for the accelerator pooling blocks.
package fs_accel_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned NCH_DEF = 13;
  localparam int unsigned WIN_DEF = 4;
  localparam int unsigned MAXW    = 32;

  // Most-negative two's complement code for a dw-bit sample, sign-extended to MAXW.
  function automatic logic signed [MAXW-1:0] min_code(input int unsigned dw);
    logic signed [MAXW-1:0] one;
    one = 1;
    return -(one <<< (dw - 1));
  endfunction

  // Signed maximum of two sign-extended samples.
  function automatic logic signed [MAXW-1:0] smax(input logic signed [MAXW-1:0] a,
                                                  input logic signed [MAXW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fs_accel_mpool_lane.sv
// One pooling channel: running signed max plus window sample counter.
module fs_accel_mpool_lane
  import fs_accel_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned WIN = WIN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          upd,
  input  logic          clr,
  output logic          done,
  output logic [DW-1:0] m
);

  localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [DW-1:0] MIN = DW'(min_code(DW));

  logic [DW-1:0] acc;
  logic [CW-1:0] cnt;

  assign m    = DW'(smax(MAXW'($signed(acc)), MAXW'($signed(din))));
  assign done = (cnt == CW'(WIN - 1));

  // Accumulate until the window closes, then restart from the neutral element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= MIN;
      cnt <= '0;
    end else if (clr) begin
      acc <= MIN;
      cnt <= '0;
    end else if (upd) begin
      if (done) begin
        acc <= MIN;
        cnt <= '0;
      end else begin
        acc <= m;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fs_accel_mpool_demux.sv
// Per-channel max-pool demux with a single-entry handshaked result register.
module fs_accel_mpool_demux
  import fs_accel_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned NCH  = NCH_DEF,
  parameter int unsigned WIN  = WIN_DEF,
  parameter int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [SELW-1:0] out_ch,
  output logic            err_sel
);

  localparam logic [DW-1:0] MIN = DW'(min_code(DW));

  logic            live;
  logic            sel_ok;
  logic            accept;
  logic [NCH-1:0]  upd;
  logic [NCH-1:0]  done_v;
  logic [DW-1:0]   m_v [NCH];
  logic            done_sel;
  logic [DW-1:0]   m_sel;

  assign in_ready = live && !clear && (!out_valid || out_ready);
  assign sel_ok   = 32'(in_sel) < NCH;
  assign accept   = in_valid && in_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    assign upd[c] = accept && sel_ok && (in_sel == SELW'(c));

    fs_accel_mpool_lane #(
      .DW  (DW),
      .WIN (WIN)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .din   (in_data),
      .upd   (upd[c]),
      .clr   (clear),
      .done  (done_v[c]),
      .m     (m_v[c])
    );
  end

  // Pick the addressed lane's candidate max and window-complete flag.
  always_comb begin
    done_sel = 1'b0;
    m_sel    = MIN;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (in_sel == SELW'(c)) begin
        done_sel = done_v[c];
        m_sel    = m_v[c];
      end
    end
  end

  // Input opens one cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  // Result register: load on window completion, drain on handshake; error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= MIN;
      out_ch    <= '0;
      err_sel   <= 1'b0;
    end else begin
      err_sel <= accept && !sel_ok;
      if (accept && sel_ok && done_sel) begin
        out_valid <= 1'b1;
        out_data  <= m_sel;
        out_ch    <= in_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fs_accel_mpool_demux.md
# fs_accel_mpool_demux

Parametrised, registered successor to the accelerator's max-pool demux. It accepts a valid/ready stream of signed samples tagged with a channel select and keeps a running maximum per channel. After `WIN` samples it emits the pooled result for that channel on a valid/ready output. It sits between the convolution/activation output and the pooled-feature writeback. With `WIN=1` it behaves as a registered, handshaked demux whose idle value is the most-negative code.

## Interface
Parameters:
- `DW`, 8: sample width, signed two's complement.
- `NCH`, 13: number of channels.
- `WIN`, 4: samples per pooling window, per channel; must be ≥1.
- `SELW`, `$clog2(NCH)` (min 1): select/channel-index width.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: block can accept a sample.
- `in_data`, in, `DW`: signed sample.
- `in_sel`, in, `SELW`: target channel.
- `clear`, in, 1: synchronous flush of all per-channel accumulators.
- `out_valid`, out, 1: pooled result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, `DW`: pooled maximum, signed.
- `out_ch`, out, `SELW`: channel the result belongs to.
- `err_sel`, out, 1: one-cycle pulse when an accepted sample had `in_sel ≥ NCH`.

## Operation
- `MIN` is −2^(DW−1), which is −128 for DW=8. It is the neutral element of max.
- Per-channel state:
  - `acc[c]` (`DW` bits, reset and initial value `MIN`).
  - `cnt[c]` (counts 0..WIN−1, reset value 0).
- Accept: a sample is accepted when `in_valid && in_ready`.
- Accepted sample with `in_sel = c < NCH`, where `m = max(acc[c], in_data)` is a signed compare:
  - If `cnt[c] < WIN−1`: `acc[c] ← m` and `cnt[c] ← cnt[c]+1`.
  - If `cnt[c] == WIN−1`: load the output register with `out_data ← m` and `out_ch ← c`, then set `out_valid ← 1`, `acc[c] ← MIN`, `cnt[c] ← 0`.
- Accepted sample with `in_sel ≥ NCH`: the sample is discarded, no channel state changes, and `err_sel` is 1 in the next cycle.
- `in_ready = !reset_state && !clear && (!out_valid || out_ready)`. The rule is conservative: input stalls whenever the output register is full and not draining, regardless of which channel the sample targets.
- Output register:
  - It is a single entry.
  - `out_valid` clears on `out_valid && out_ready` unless it is reloaded in the same cycle. A simultaneous drain and reload is legal and yields back-to-back results.
  - `out_data` and `out_ch` hold their values while `out_valid && !out_ready`.
- `clear`:
  - All `acc ← MIN` and all `cnt ← 0`.
  - The pending output register is not affected.
  - No input is accepted in a `clear` cycle (`in_ready=0`).
- Partial windows are never emitted. They are lost only on `clear` or `reset`.
- Channels are fully independent. Interleaving selects in any order is legal.

## Timing
- Reset values (asynchronous, while `reset=1`): `out_valid=0`, `out_data=MIN`, `out_ch=0`, `err_sel=0`, `in_ready=0`, all `acc=MIN`, all `cnt=0`.
- `in_ready` rises in the first cycle after `reset` deasserts.
- Latency: the window-completing sample is accepted at edge N, and `out_valid=1` with the result is visible after edge N.
- Throughput: one sample per cycle while `out_ready=1`.
- `WIN=1`: every valid sample is emitted one cycle later, tagged with its channel.
- Reset asserted mid-window or with a pending output: all state returns to reset values immediately, and the pending result is dropped.
- `err_sel` is registered, high for exactly one cycle per bad sample.

## Structure
- Shared package `fs_accel_pkg`: `MIN` as a function of `DW`, the default `DW`/`NCH`/`WIN` constants, and a signed-max function.
- One natural sub-module, `fs_accel_mpool_lane`. Each lane holds one channel's `acc` and `cnt`, takes an update-enable and a clear, and outputs `done` and `m`. The lane is instantiated `NCH` times through a generate loop.
- The top level contains the select decode, range check, handshake, and output register.

## Test plan
- Reset: hold `reset` 3 cycles -> `out_valid=0`, `out_data=-128`, `in_ready=0`. After release -> `in_ready=1`.
- Single channel, WIN=4: samples 5, −3, 17, 2 on ch 3 with `out_ready=1` -> exactly one result, `out_data=17`, `out_ch=3`, one cycle after the 4th accept. Then `acc[3]` is back to −128 (next window of −128 ×4 yields −128).
- Interleave: ch0 gets −10, −20, −5, −7 and ch12 gets 100, 127, −128, 0, alternating per cycle -> results ch0 = −5 and ch12 = 127, in window-completion order.
- Back-pressure: complete a window with `out_ready=0` -> `in_ready=0`, `out_data` stable for 5 cycles. Raise `out_ready` while the next window completes in the same cycle -> no result lost or duplicated.
- Errors and clear: sample with `in_sel=13` -> `err_sel` pulse, no channel change. Send 2 samples on ch1, pulse `clear`, then 4 samples of 1 -> result 1, not the pre-clear max.
- WIN=1 build: stream 9 on ch 7 -> `out_data=9`, `out_ch=7` the next cycle, every cycle.
